vedic_mul8_seq: RTL

Multi-cycle 8x8 multiplier controller built around one combinational 4x4 Vedic multiplier core (`VEDICMULTIPLIER4X4`, ports `a[3:0]`, `b[3:0]`, `p[7:0]`), instantiated inside this block. It accepts operand pairs over a valid/ready handshake and sequences the four 4x4 partial products through the shared core. It shifts and accumulates them into a 16-bit result and presents that result over a second valid/ready handshake. Optional signed mode uses sign-magnitude correction around the unsigned core.

---
 rtl/vedic_mul8_seq_if.sv | 23 ++
 rtl/vedic_mul8_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/vedic_mul8_seq_if.sv
// Operand / product handshake bundle for the sequential 8x8 Vedic multiplier.
// The slave side is the multiplier; the master side drives operands and consumes products.
interface vedic_mul8_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, out_valid, p, busy
  );

  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/vedic_mul8_seq.sv
// Multi-cycle 8x8 multiplier: four 4x4 partial products through one shared Vedic core,
// shift-accumulated into 16 bits, with sign-magnitude correction for signed operands.

module VEDICMULTIPLIER4X4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  // Urdhva-tiryagbhyam: 2x2 vertical/crosswise blocks, then recombined
  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic c;
    c   = x[1] & y[0] & x[0] & y[1];
    vm2 = {(x[1] & y[1]) & c, (x[1] & y[1]) ^ c, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
  endfunction

  always_comb begin
    q0 = vm2(a[1:0], b[1:0]);
    q1 = vm2(a[3:2], b[1:0]);
    q2 = vm2(a[1:0], b[3:2]);
    q3 = vm2(a[3:2], b[3:2]);
    p  = {4'b0, q0} + {2'b0, ({2'b0, q1} + {2'b0, q2}), 2'b0} + {q3, 4'b0};
  end
endmodule

module vedic_mul8_seq (
  input  logic                    clk,
  input  logic                    rst_n,
  vedic_mul8_seq_if.slave         bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  ma_q, ma_d;
  logic [7:0]  mb_q, mb_d;
  logic        neg_q, neg_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] p_q, p_d;

  logic [3:0]  core_a, core_b;
  logic [7:0]  core_p;
  logic [3:0]  shamt;
  logic [15:0] acc_sum;
  logic        accept;

  VEDICMULTIPLIER4X4 u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  assign accept = bus.in_valid && (state_q == S_IDLE);

  always_comb begin
    core_a = ma_q[3:0];
    core_b = mb_q[3:0];
    shamt  = 4'd0;
    unique case (step_q)
      2'd0: begin core_a = ma_q[3:0]; core_b = mb_q[3:0]; shamt = 4'd0; end
      2'd1: begin core_a = ma_q[3:0]; core_b = mb_q[7:4]; shamt = 4'd4; end
      2'd2: begin core_a = ma_q[7:4]; core_b = mb_q[3:0]; shamt = 4'd4; end
      2'd3: begin core_a = ma_q[7:4]; core_b = mb_q[7:4]; shamt = 4'd8; end
      default: ;
    endcase
    acc_sum = acc_q + ({8'b0, core_p} << shamt);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    p_d     = p_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          ma_d    = (bus.sgn && bus.a[7]) ? 8'(~bus.a + 8'd1) : bus.a;
          mb_d    = (bus.sgn && bus.b[7]) ? 8'(~bus.b + 8'd1) : bus.b;
          neg_d   = bus.sgn && (bus.a[7] ^ bus.b[7]);
          acc_d   = 16'h0000;
          step_d  = 2'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          p_d     = neg_q ? 16'(~acc_sum + 16'd1) : acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      ma_q    <= 8'h00;
      mb_q    <= 8'h00;
      neg_q   <= 1'b0;
      acc_q   <= 16'h0000;
      p_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_MUL) || (state_q == S_DONE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.p         = p_q;
endmodule
